// File: rtl/matrix_operand_streamer.sv
// matrix_operand_streamer
// Streams operand beats to a matrix engine. A group of GROUP rows is read
// from the A SRAM and packed into a_vec, then B rows are streamed one per
// beat against that group through a valid/ready handshake. The A group is
// refreshed every GROUP beats until num_rows B rows have been sent.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start, abort        begin a stream (IDLE only) / cancel back to IDLE
//   num_rows            B rows to stream, latched on start
//   a_rd_en/a_addr      A SRAM read port, a_rdata valid one cycle later
//   b_rd_en/b_addr      B SRAM read port, b_rdata valid one cycle later
//   a_vec, b_vec        packed A group (row 0 in MSBs) and current B row
//   vec_valid/ready     beat handshake
//   a_new               first beat of an A group is on the output
//   busy, done          not in IDLE / one-cycle completion pulse
module matrix_operand_streamer #(
  parameter int unsigned ROW_W  = 264,
  parameter int unsigned GROUP  = 16,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDR_W:0]        num_rows,
  output logic                   a_rd_en,
  output logic [ADDR_W-1:0]      a_addr,
  input  logic [ROW_W-1:0]       a_rdata,
  output logic                   b_rd_en,
  output logic [ADDR_W-1:0]      b_addr,
  input  logic [ROW_W-1:0]       b_rdata,
  output logic [GROUP*ROW_W-1:0] a_vec,
  output logic [ROW_W-1:0]       b_vec,
  output logic                   vec_valid,
  input  logic                   vec_ready,
  output logic                   a_new,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned SLOT_W = (GROUP > 1) ? $clog2(GROUP) : 1;
  localparam int unsigned LOAD_W = $clog2(GROUP + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD_A = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  logic [1:0]        state_q, state_n;
  logic [ADDR_W:0]   num_rows_q, num_rows_n;
  logic [ADDR_W:0]   row_cnt_q, row_cnt_n;
  logic [LOAD_W-1:0] load_idx_q, load_idx_n;
  logic [SLOT_W-1:0] beat_idx_q, beat_idx_n;
  logic              b_first_q, b_first_n;
  logic              a_rd_en_n;
  logic [ADDR_W-1:0] a_addr_n, b_addr_n;
  logic              vec_valid_n, a_new_n, busy_n, done_n;

  logic              a_cap_q;
  logic [SLOT_W-1:0] a_slot_q;
  logic              b_fresh_q;
  logic [ROW_W-1:0]  b_q;

  logic [ADDR_W:0]   row_inc;
  logic              xfer, last_row, last_beat;

  assign row_inc   = row_cnt_q + (ADDR_W+1)'(1);
  assign xfer      = (state_q == ST_STREAM) && vec_valid && vec_ready;
  assign last_row  = (row_inc == num_rows_q);
  assign last_beat = (beat_idx_q == SLOT_W'(GROUP - 1));

  // B reads: the group's first read follows the last A read; later ones ride on transfers
  assign b_rd_en = (b_first_q || (xfer && !last_row && !last_beat)) && !abort;

  // Fresh SRAM data is presented directly; the held copy covers stalls
  assign b_vec = b_fresh_q ? b_rdata : b_q;

  // Next-state and registered-output logic
  always_comb begin
    state_n     = state_q;
    num_rows_n  = num_rows_q;
    row_cnt_n   = row_cnt_q;
    load_idx_n  = load_idx_q;
    beat_idx_n  = beat_idx_q;
    b_first_n   = 1'b0;
    a_rd_en_n   = 1'b0;
    a_addr_n    = a_addr;
    b_addr_n    = b_rd_en ? (b_addr + ADDR_W'(1)) : b_addr;
    vec_valid_n = vec_valid;
    a_new_n     = a_new;
    done_n      = 1'b0;

    if (abort) begin
      state_n     = ST_IDLE;
      vec_valid_n = 1'b0;
      a_new_n     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            num_rows_n = num_rows;
            row_cnt_n  = '0;
            beat_idx_n = '0;
            load_idx_n = '0;
            a_addr_n   = '0;
            b_addr_n   = '0;
            if (num_rows == '0) begin
              state_n = ST_FINISH;
              done_n  = 1'b1;
            end else begin
              state_n   = ST_LOAD_A;
              a_rd_en_n = 1'b1;
            end
          end
        end
        ST_LOAD_A: begin
          // load_idx == GROUP: last A row is returning, first B read is out
          if (load_idx_q == LOAD_W'(GROUP)) begin
            state_n     = ST_STREAM;
            vec_valid_n = 1'b1;
            a_new_n     = 1'b1;
          end else if (load_idx_q == LOAD_W'(GROUP - 1)) begin
            load_idx_n = LOAD_W'(GROUP);
            b_first_n  = 1'b1;
          end else begin
            load_idx_n = load_idx_q + LOAD_W'(1);
            a_rd_en_n  = 1'b1;
            a_addr_n   = a_addr + ADDR_W'(1);
          end
        end
        ST_STREAM: begin
          if (xfer) begin
            a_new_n   = 1'b0;
            row_cnt_n = row_inc;
            if (last_row) begin
              state_n     = ST_FINISH;
              vec_valid_n = 1'b0;
              done_n      = 1'b1;
            end else if (last_beat) begin
              state_n     = ST_LOAD_A;
              vec_valid_n = 1'b0;
              beat_idx_n  = '0;
              load_idx_n  = '0;
              a_rd_en_n   = 1'b1;
              a_addr_n    = ADDR_W'(row_inc);
            end else begin
              beat_idx_n = beat_idx_q + SLOT_W'(1);
            end
          end
        end
        ST_FINISH: state_n = ST_IDLE;
        default:   state_n = ST_IDLE;
      endcase
    end

    busy_n = (state_n != ST_IDLE);
  end

  // Control state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      num_rows_q <= '0;
      row_cnt_q  <= '0;
      load_idx_q <= '0;
      beat_idx_q <= '0;
      b_first_q  <= 1'b0;
      a_rd_en    <= 1'b0;
      a_addr     <= '0;
      b_addr     <= '0;
      vec_valid  <= 1'b0;
      a_new      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_n;
      num_rows_q <= num_rows_n;
      row_cnt_q  <= row_cnt_n;
      load_idx_q <= load_idx_n;
      beat_idx_q <= beat_idx_n;
      b_first_q  <= b_first_n;
      a_rd_en    <= a_rd_en_n;
      a_addr     <= a_addr_n;
      b_addr     <= b_addr_n;
      vec_valid  <= vec_valid_n;
      a_new      <= a_new_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

  // Operand datapath: A rows land in their slot the cycle their data returns
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_vec     <= '0;
      a_cap_q   <= 1'b0;
      a_slot_q  <= '0;
      b_fresh_q <= 1'b0;
      b_q       <= '0;
    end else begin
      a_cap_q   <= a_rd_en;
      if (a_rd_en) a_slot_q <= SLOT_W'(load_idx_q);
      b_fresh_q <= b_rd_en;
      if (b_fresh_q) b_q <= b_rdata;
      if (a_cap_q) begin
        for (int k = 0; k < int'(GROUP); k++) begin
          if (a_slot_q == SLOT_W'(k)) a_vec[(int'(GROUP) - 1 - k)*int'(ROW_W) +: ROW_W] <= a_rdata;
        end
      end
    end
  end

endmodule
